blake2s_block_fmt: RTL and testbench

Message block formatter placed directly upstream of the BLAKE2s hash core. It accepts the key and message as a byte stream with a valid/ready handshake and buffers one 64-byte block. It zero-pads the key block and the final message block, then replays each block to the core as 64 indexed byte beats with stable first/last flags. It also produces the message length `ll_o` and latched key length `kk_o` that the core consumes.

---
 rtl/blake2s_block_fmt.sv | 154 +++++++++++++++
 tb/tb_blake2s_block_fmt.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blake2s_block_fmt.sv
// Block formatter in front of the BLAKE2s core: collects key/message bytes
// into a one-block buffer, then replays each block as indexed byte beats with
// zero padding derived from the fill count, plus first/last block flags.
module blake2s_block_fmt #(
    parameter int BLOCK_BYTES = 64,
    parameter int LL_W        = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start_i,
    input  logic [6:0]                     kk_i,
    input  logic                           empty_i,
    input  logic                           byte_v_i,
    input  logic [7:0]                     byte_i,
    input  logic                           byte_last_i,
    output logic                           byte_rdy_o,
    input  logic                           core_ready_i,
    output logic                           data_v_o,
    output logic [7:0]                     data_o,
    output logic [$clog2(BLOCK_BYTES)-1:0] data_idx_o,
    output logic                           block_first_o,
    output logic                           block_last_o,
    output logic [6:0]                     kk_o,
    output logic [LL_W-1:0]                ll_o,
    output logic                           busy_o
);
    localparam int         IDX_W  = $clog2(BLOCK_BYTES);
    localparam int         CNT_W  = IDX_W + 1;
    localparam logic [6:0] KK_MAX = 7'd32;

    typedef enum logic [2:0] {S_IDLE, S_KEY, S_FILL, S_WAIT, S_DRAIN} state_t;

    state_t           state_q;
    logic [7:0]       buf_q [BLOCK_BYTES];
    logic [CNT_W-1:0] cnt_q;
    logic             first_q;
    logic             last_q;
    logic [6:0]       kk_clamp;
    logic             accept;
    logic [IDX_W-1:0] idx_nxt;
    logic [7:0]       beat_nxt;

    // Clamped key length, handshake strobe and the byte for the next beat
    always_comb begin
        kk_clamp = (kk_i > KK_MAX) ? KK_MAX : kk_i;
        accept   = byte_rdy_o & byte_v_i;
        idx_nxt  = (state_q == S_DRAIN) ? data_idx_o + IDX_W'(1) : '0;
        beat_nxt = ({1'b0, idx_nxt} < cnt_q) ? buf_q[idx_nxt] : 8'h00;
    end

    // Block buffer: written at the fill count, never cleared
    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            buf_q[cnt_q[IDX_W-1:0]] <= byte_i;
        end
    end

    // Control FSM with registered handshake and beat outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            first_q       <= 1'b0;
            last_q        <= 1'b0;
            byte_rdy_o    <= 1'b0;
            data_v_o      <= 1'b0;
            data_o        <= '0;
            data_idx_o    <= '0;
            block_first_o <= 1'b0;
            block_last_o  <= 1'b0;
            kk_o          <= '0;
            ll_o          <= '0;
            busy_o        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        kk_o    <= kk_clamp;
                        ll_o    <= '0;
                        cnt_q   <= '0;
                        first_q <= 1'b1;
                        busy_o  <= 1'b1;
                        if (kk_clamp != '0) begin
                            state_q    <= S_KEY;
                            last_q     <= 1'b0;
                            byte_rdy_o <= 1'b1;
                        end else if (empty_i) begin
                            state_q <= S_WAIT;
                            last_q  <= 1'b1;
                        end else begin
                            state_q    <= S_FILL;
                            last_q     <= 1'b0;
                            byte_rdy_o <= 1'b1;
                        end
                    end
                end
                S_KEY: begin
                    if (accept) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        // byte_last_i before the final key byte is ignored
                        if (cnt_q + CNT_W'(1) == CNT_W'(kk_o)) begin
                            state_q    <= S_WAIT;
                            byte_rdy_o <= 1'b0;
                            last_q     <= byte_last_i;
                        end
                    end
                end
                S_FILL: begin
                    if (accept) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        ll_o  <= ll_o + LL_W'(1);
                        if (cnt_q == CNT_W'(BLOCK_BYTES - 1) || byte_last_i) begin
                            state_q    <= S_WAIT;
                            byte_rdy_o <= 1'b0;
                            last_q     <= byte_last_i;
                        end
                    end
                end
                S_WAIT: begin
                    if (core_ready_i) begin
                        state_q       <= S_DRAIN;
                        data_v_o      <= 1'b1;
                        data_idx_o    <= '0;
                        data_o        <= beat_nxt;
                        block_first_o <= first_q;
                        block_last_o  <= last_q;
                    end
                end
                S_DRAIN: begin
                    if (data_idx_o == IDX_W'(BLOCK_BYTES - 1)) begin
                        data_v_o      <= 1'b0;
                        data_o        <= '0;
                        data_idx_o    <= '0;
                        block_first_o <= 1'b0;
                        block_last_o  <= 1'b0;
                        first_q       <= 1'b0;
                        cnt_q         <= '0;
                        if (last_q) begin
                            state_q <= S_IDLE;
                            busy_o  <= 1'b0;
                        end else begin
                            state_q    <= S_FILL;
                            byte_rdy_o <= 1'b1;
                        end
                    end else begin
                        data_idx_o <= idx_nxt;
                        data_o     <= beat_nxt;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_blake2s_block_fmt.sv
// Self-checking bench for blake2s_block_fmt: directed and randomized messages
// compared beat-by-beat against a block-level reference model.
module tb_blake2s_block_fmt;
    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [6:0]  kk_i;
    logic        empty_i;
    logic        byte_v_i;
    logic [7:0]  byte_i;
    logic        byte_last_i;
    logic        byte_rdy_o;
    logic        core_ready_i;
    logic        data_v_o;
    logic [7:0]  data_o;
    logic [5:0]  data_idx_o;
    logic        block_first_o;
    logic        block_last_o;
    logic [6:0]  kk_o;
    logic [63:0] ll_o;
    logic        busy_o;

    always #5 clk = ~clk;

    blake2s_block_fmt #(.BLOCK_BYTES(64), .LL_W(64)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .kk_i(kk_i),
        .empty_i(empty_i), .byte_v_i(byte_v_i), .byte_i(byte_i),
        .byte_last_i(byte_last_i), .byte_rdy_o(byte_rdy_o),
        .core_ready_i(core_ready_i), .data_v_o(data_v_o), .data_o(data_o),
        .data_idx_o(data_idx_o), .block_first_o(block_first_o),
        .block_last_o(block_last_o), .kk_o(kk_o), .ll_o(ll_o), .busy_o(busy_o)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [5:0] idx;
        logic       f;
        logic       l;
    } beat_t;

    logic [7:0] key_q[$];
    logic [7:0] msg_q[$];
    logic [7:0] s_q[$];
    beat_t      exp_q[$];
    beat_t      got_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cur_kk;

    // Capture every beat presented to the core
    always @(negedge clk) begin
        if (data_v_o) got_q.push_back(beat_t'({data_o, data_idx_o, block_first_o, block_last_o}));
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s: observed=timeout expected=event", tag);
    endtask

    task automatic emit(input bit from_key, input int off, input int len, input int b, input int nb);
        logic [7:0] d;
        for (int i = 0; i < 64; i++) begin
            if (i < len) d = from_key ? key_q[off + i] : msg_q[off + i];
            else         d = 8'h00;
            exp_q.push_back(beat_t'({d, 6'(i), b == 0, b == nb - 1}));
        end
    endtask

    // Reference: key block (if any), then message split into 64-byte chunks
    task automatic build_model(input int kkc);
        int n, nb, b;
        n = msg_q.size();
        nb = ((kkc > 0) ? 1 : 0) + (n + 63) / 64;
        if (nb == 0) nb = 1;
        b = 0;
        exp_q.delete();
        if (kkc > 0) begin
            emit(1'b1, 0, kkc, b, nb);
            b++;
        end else if (n == 0) begin
            emit(1'b0, 0, 0, b, nb);
            b++;
        end
        for (int off = 0; off < n; off += 64) begin
            emit(1'b0, off, (n - off > 64) ? 64 : n - off, b, nb);
            b++;
        end
    endtask

    task automatic rand_bytes(input int nkey, input int nmsg);
        key_q.delete();
        msg_q.delete();
        repeat (nkey) key_q.push_back(8'($urandom_range(0, 255)));
        repeat (nmsg) msg_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic run_start(input string name, input int kk, input bit empty);
        cur_kk = (kk > 32) ? 32 : kk;
        build_model(cur_kk);
        got_q.delete();
        @(negedge clk);
        start_i = 1'b1;
        kk_i    = 7'(kk);
        empty_i = empty;
        @(negedge clk);
        start_i = 1'b0;
        empty_i = 1'b0;
        kk_i    = 7'($urandom_range(0, 127));
        chk({name, "_busy_after_start"}, 64'(busy_o), 64'd1);
        chk({name, "_rdy_after_start"}, 64'(byte_rdy_o), 64'((cur_kk > 0 || !empty) ? 1 : 0));
        chk({name, "_kk_latched"}, 64'(kk_o), 64'(cur_kk));
    endtask

    task automatic feed(input string name, input bit gaps);
        int  i = 0;
        int  budget = 0;
        bit  v;
        s_q.delete();
        foreach (key_q[k]) s_q.push_back(key_q[k]);
        foreach (msg_q[k]) s_q.push_back(msg_q[k]);
        while (i < s_q.size()) begin
            @(negedge clk);
            if (byte_rdy_o) begin
                v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                byte_v_i    = v;
                byte_i      = v ? s_q[i] : 8'($urandom_range(0, 255));
                byte_last_i = v ? (i == s_q.size() - 1) : 1'($urandom_range(0, 1));
                if (v) i++;
            end else begin
                // Offered while not ready: must be ignored
                byte_v_i    = 1'b1;
                byte_i      = 8'($urandom_range(0, 255));
                byte_last_i = 1'($urandom_range(0, 1));
            end
            budget++;
            if (budget > 5000) begin
                timeout({name, "_feed"});
                break;
            end
        end
        @(negedge clk);
        byte_v_i    = 1'b0;
        byte_last_i = 1'b0;
    endtask

    task automatic finish_check(input string name);
        int budget = 0;
        while (busy_o && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        if (busy_o) timeout({name, "_idle"});
        chk({name, "_nbeats"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                chk($sformatf("%s_beat%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
        end
        chk({name, "_ll"}, ll_o, 64'(msg_q.size()));
        chk({name, "_kk"}, 64'(kk_o), 64'(cur_kk));
        chk({name, "_flags_idle"}, 64'({data_v_o, block_first_o, block_last_o, byte_rdy_o}), 64'd0);
    endtask

    task automatic set_abc();
        key_q.delete();
        msg_q.delete();
        msg_q.push_back(8'h61);
        msg_q.push_back(8'h62);
        msg_q.push_back(8'h63);
    endtask

    initial begin
        int budget;
        reset        = 1'b1;
        start_i      = 1'b0;
        kk_i         = '0;
        empty_i      = 1'b0;
        byte_v_i     = 1'b0;
        byte_i       = '0;
        byte_last_i  = 1'b0;
        core_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_outputs",
            64'({byte_rdy_o, data_v_o, block_first_o, block_last_o, busy_o, data_idx_o, data_o, kk_o}),
            64'd0);
        chk("reset_ll", ll_o, 64'd0);

        // Unkeyed "abc"
        set_abc();
        run_start("abc", 0, 1'b0);
        feed("abc", 1'b0);
        finish_check("abc");

        // Unkeyed empty message: one all-zero block
        key_q.delete();
        msg_q.delete();
        run_start("empty", 0, 1'b1);
        finish_check("empty");

        // Exactly one full block, then one byte over
        key_q.delete();
        msg_q.delete();
        for (int i = 0; i < 64; i++) msg_q.push_back(8'(i));
        run_start("full64", 0, 1'b0);
        feed("full64", 1'b0);
        finish_check("full64");
        msg_q.push_back(8'h40);
        run_start("full65", 0, 1'b0);
        feed("full65", 1'b0);
        finish_check("full65");

        // Two-byte key followed by a one-byte message, then key only
        key_q.delete();
        msg_q.delete();
        key_q.push_back(8'h01);
        key_q.push_back(8'h02);
        msg_q.push_back(8'h61);
        run_start("key2_msg1", 2, 1'b0);
        feed("key2_msg1", 1'b0);
        finish_check("key2_msg1");
        msg_q.delete();
        run_start("key2_only", 2, 1'b0);
        feed("key2_only", 1'b0);
        finish_check("key2_only");

        // Oversized key length clamps to 32, random message with gaps
        rand_bytes(32, 100);
        run_start("key40_clamp", 40, 1'b0);
        feed("key40_clamp", 1'b1);
        finish_check("key40_clamp");

        // Randomized messages with input gaps
        for (int r = 0; r < 4; r++) begin
            int kk, n;
            kk = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 34);
            n  = $urandom_range(1, 150);
            rand_bytes((kk > 32) ? 32 : kk, n);
            run_start($sformatf("rand%0d", r), kk, 1'b0);
            feed($sformatf("rand%0d", r), 1'b1);
            finish_check($sformatf("rand%0d", r));
        end

        // Core backpressure: block held in WAIT until core_ready_i rises
        core_ready_i = 1'b0;
        rand_bytes(0, 10);
        run_start("hold", 0, 1'b0);
        feed("hold", 1'b1);
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("hold_wait%0d", c), 64'({data_v_o, byte_rdy_o, busy_o}), 64'b001);
            if (c < 9) @(negedge clk);
        end
        core_ready_i = 1'b1;
        @(negedge clk);
        chk("hold_first_beat", 64'({data_v_o, data_idx_o}), 64'({1'b1, 6'd0}));
        finish_check("hold");

        // Reset in the middle of a drain, then a clean "abc"
        set_abc();
        run_start("abort", 0, 1'b0);
        feed("abort", 1'b0);
        budget = 0;
        while (!(data_v_o && data_idx_o == 6'd20) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 200) timeout("abort_idx20");
        reset = 1'b1;
        @(negedge clk);
        chk("abort_outputs",
            64'({byte_rdy_o, data_v_o, block_first_o, block_last_o, busy_o, data_idx_o, data_o, kk_o}),
            64'd0);
        chk("abort_ll", ll_o, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_no_beats", 64'({data_v_o, busy_o}), 64'd0);
        set_abc();
        run_start("abc_again", 0, 1'b0);
        feed("abc_again", 1'b0);
        finish_check("abc_again");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
